// File: rtl/mp3_pkg.sv
// Shared SCI opcodes, VS10xx register addresses and the scheduler state type.
package mp3_pkg;

    localparam logic [7:0] SCI_OP_WRITE = 8'h02;
    localparam logic [7:0] SCI_OP_READ  = 8'h03;

    localparam logic [7:0] SCI_MODE     = 8'h00;
    localparam logic [7:0] SCI_BASS     = 8'h02;
    localparam logic [7:0] SCI_CLOCKF   = 8'h03;
    localparam logic [7:0] SCI_VOL      = 8'h0B;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        WAIT_DREQ,
        SHIFT,
        GAP
    } sci_state_t;

endpackage

// File: rtl/mp3_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module mp3_rr_arb #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    g,
    output logic             valid
);

    int unsigned idx;

    always_comb begin
        g     = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!valid && req[PW'(idx)]) begin
                valid = 1'b1;
                g     = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/mp3_sci_sched.sv
// Round-robin SCI write scheduler for the VS10xx; all state changes on negedge clk.
// Define MP3_SCI_TIMEOUT_EN to add the HOLD/WAIT_DREQ watchdog (TIMEOUT_CYC, err pulse).
module mp3_sci_sched
    import mp3_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GAP_CYC = 2000
`ifdef MP3_SCI_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [8*N_REQ-1:0]  wr_addr,
    input  logic [16*N_REQ-1:0] wr_data,
    output logic [N_REQ-1:0]    ack,
    output logic                err,
    output logic                busy,
    input  logic                dreq,
    input  logic                sdi_idle,
    output logic                sdi_hold,
    output logic                xcs,
    output logic                si,
    output logic                sck_en
);

    localparam int PW = $clog2(N_REQ);
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    sci_state_t        state, state_nx;
    logic [PW-1:0]     ptr, ptr_nx, g_q, g_nx, g_arb;
    logic              arb_valid;
    logic [31:0]       shreg, shreg_nx;
    logic [5:0]        cnt, cnt_nx;
    logic [GW-1:0]     gcnt, gcnt_nx;
    logic              xcs_nx, si_nx, sck_en_nx, sdi_hold_nx;
    logic [N_REQ-1:0]  ack_nx;
`ifdef MP3_SCI_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0]     wcnt, wcnt_nx;
    logic              err_nx, wdog_hit;
`endif

    mp3_rr_arb #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .g     (g_arb),
        .valid (arb_valid)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        g_nx        = g_q;
        shreg_nx    = shreg;
        cnt_nx      = cnt;
        gcnt_nx     = gcnt;
        xcs_nx      = xcs;
        si_nx       = si;
        sck_en_nx   = sck_en;
        sdi_hold_nx = sdi_hold;
        ack_nx      = '0;
`ifdef MP3_SCI_TIMEOUT_EN
        err_nx      = 1'b0;
        wcnt_nx     = wcnt;
        wdog_hit    = (wcnt == WW'(TIMEOUT_CYC - 1));
`endif
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    g_nx        = g_arb;
                    ptr_nx      = PW'((int'(g_arb) + 1) % N_REQ);
                    shreg_nx    = {SCI_OP_WRITE, wr_addr[8*int'(g_arb) +: 8],
                                   wr_data[16*int'(g_arb) +: 16]};
                    sdi_hold_nx = 1'b1;
                    state_nx    = HOLD;
`ifdef MP3_SCI_TIMEOUT_EN
                    wcnt_nx     = '0;
`endif
                end
            end
            HOLD, WAIT_DREQ: begin
                if (state == HOLD && sdi_idle) begin
                    state_nx = WAIT_DREQ;
                end else if (state == WAIT_DREQ && dreq) begin
                    state_nx = SHIFT;
                    cnt_nx   = 6'd32;
                end
`ifdef MP3_SCI_TIMEOUT_EN
                // Progress wins over the watchdog when both land on the same edge.
                else if (wdog_hit) begin
                    ack_nx[g_q] = 1'b1;
                    err_nx      = 1'b1;
                    sdi_hold_nx = 1'b0;
                    state_nx    = IDLE;
                end
                wcnt_nx = wcnt + 1'b1;
`endif
            end
            SHIFT: begin
                if (cnt != '0) begin
                    xcs_nx    = 1'b0;
                    sck_en_nx = 1'b1;
                    si_nx     = shreg[5'(cnt - 6'd1)];
                    cnt_nx    = cnt - 6'd1;
                end else begin
                    xcs_nx    = 1'b1;
                    sck_en_nx = 1'b0;
                    si_nx     = 1'b0;
                    gcnt_nx   = GW'(GAP_CYC);
                    state_nx  = GAP;
                end
            end
            GAP: begin
                if (gcnt != '0) begin
                    gcnt_nx = gcnt - 1'b1;
                end else begin
                    ack_nx[g_q] = 1'b1;
                    sdi_hold_nx = 1'b0;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            g_q      <= '0;
            shreg    <= '0;
            cnt      <= '0;
            gcnt     <= '0;
            xcs      <= 1'b1;
            si       <= 1'b0;
            sck_en   <= 1'b0;
            sdi_hold <= 1'b0;
            ack      <= '0;
`ifdef MP3_SCI_TIMEOUT_EN
            err      <= 1'b0;
            wcnt     <= '0;
`endif
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            g_q      <= g_nx;
            shreg    <= shreg_nx;
            cnt      <= cnt_nx;
            gcnt     <= gcnt_nx;
            xcs      <= xcs_nx;
            si       <= si_nx;
            sck_en   <= sck_en_nx;
            sdi_hold <= sdi_hold_nx;
            ack      <= ack_nx;
`ifdef MP3_SCI_TIMEOUT_EN
            err      <= err_nx;
            wcnt     <= wcnt_nx;
`endif
        end
    end

`ifndef MP3_SCI_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mp3_sci_sched.sv
// Directed self-checking bench for mp3_sci_sched (GAP_CYC=4; timeout scenario follows the macro).
module tb_mp3_sci_sched;

    localparam int GAP = 4;
    localparam int ACK_EDGE = 36 + GAP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [3:0]  ack;
    logic        err, busy;
    logic        dreq = 1'b1;
    logic        sdi_idle = 1'b1;
    logic        sdi_hold, xcs, si, sck_en;

    int checks = 0;
    int failures = 0;

    mp3_sci_sched #(
        .N_REQ   (4),
        .GAP_CYC (GAP)
`ifdef MP3_SCI_TIMEOUT_EN
        , .TIMEOUT_CYC (64)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .dreq     (dreq),
        .sdi_idle (sdi_idle),
        .sdi_hold (sdi_hold),
        .xcs      (xcs),
        .si       (si),
        .sck_en   (sck_en)
    );

    always #5 clk = ~clk;

    // Observes one transaction edge by edge (sampled at posedge, DUT moves on negedge).
    // Edge 0 is the first negedge after the call; requesters drop req on their ack.
    task automatic run_txn(input int maxe, input int idle_rise, input int dreq_rise,
                           input int drop_at, output logic [31:0] bits, output int nbits,
                           output int first_shift, output int ack_edge,
                           output logic [3:0] ack_vec, output logic err_seen,
                           output bit hold_ok, output bit contig, output int bad_sck);
        int last_low;
        bits = '0; nbits = 0; first_shift = -1; ack_edge = -1; ack_vec = '0;
        err_seen = 1'b0; hold_ok = 1'b1; contig = 1'b1; bad_sck = 0; last_low = -1;
        for (int e = 0; e < maxe; e++) begin
            @(posedge clk);
            if (sck_en !== ~xcs) bad_sck++;
            if (xcs === 1'b0) begin
                if (first_shift < 0) first_shift = e;
                if (last_low >= 0 && last_low != e - 1) contig = 1'b0;
                last_low = e;
                bits = {bits[30:0], si};
                nbits++;
                if (drop_at > 0 && nbits == drop_at) dreq = 1'b0;
            end else if (first_shift < 0 && ack === 4'b0000 && sdi_hold !== 1'b1) begin
                hold_ok = 1'b0;
            end
            if (ack !== 4'b0000) begin
                ack_edge = e;
                ack_vec = ack;
                err_seen = err;
                req = req & ~ack;
                break;
            end
            if (e + 1 == idle_rise) sdi_idle = 1'b1;
            if (e + 1 == dreq_rise) dreq = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if ({xcs, si, sck_en, sdi_hold, ack, err, busy} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got xcs=%b si=%b sck_en=%b hold=%b ack=%b err=%b busy=%b, want 1 0 0 0 0000 0 0",
                     xcs, si, sck_en, sdi_hold, ack, err, busy);
        end
        rst = 1'b1;
    endtask

    task automatic test_single_write;
        logic [31:0] bits; int nbits, fs, ae, bad; logic [3:0] av; logic es; bit hok, ctg;
        wr_addr[15:8] = 8'h0B; wr_data[31:16] = 16'h2020;
        dreq = 1'b1; sdi_idle = 1'b1; req = 4'b0010;
        run_txn(100, -1, -1, 0, bits, nbits, fs, ae, av, es, hok, ctg, bad);
        checks++; if (bits !== 32'h020B2020 || nbits != 32) begin failures++;
            $display("FAIL single_bits: got %h (%0d bits), want 020b2020 (32 bits)", bits, nbits); end
        checks++; if (fs != 3) begin failures++;
            $display("FAIL single_first_shift: got edge %0d, want 3", fs); end
        checks++; if (ae != ACK_EDGE || av !== 4'b0010 || es !== 1'b0) begin failures++;
            $display("FAIL single_ack: got edge %0d ack=%b err=%b, want edge %0d ack=0010 err=0", ae, av, es, ACK_EDGE); end
        checks++; if (!hok || !ctg || bad != 0) begin failures++;
            $display("FAIL single_framing: got hold_ok=%0d contig=%0d sck_mismatch=%0d, want 1 1 0", hok, ctg, bad); end
        @(posedge clk);
        checks++; if (ack !== 4'b0000 || busy !== 1'b0 || sdi_hold !== 1'b0) begin failures++;
            $display("FAIL single_after_ack: got ack=%b busy=%b hold=%b, want 0000 0 0", ack, busy, sdi_hold); end
    endtask

    task automatic test_streamer_sync;
        logic [31:0] bits; int nbits, fs, ae, bad; logic [3:0] av; logic es; bit hok, ctg;
        wr_addr[23:16] = 8'h02; wr_data[47:32] = 16'h7A15;
        dreq = 1'b1; sdi_idle = 1'b0; req = 4'b0100;
        run_txn(200, 50, -1, 0, bits, nbits, fs, ae, av, es, hok, ctg, bad);
        checks++; if (!hok || fs != 52) begin failures++;
            $display("FAIL sync_hold: got hold_ok=%0d first_shift=%0d, want 1 52", hok, fs); end
        checks++; if (bits !== 32'h02027A15 || ae != 52 + 37 || av !== 4'b0100) begin failures++;
            $display("FAIL sync_write: got %h ack edge %0d ack=%b, want 02027a15 edge 89 ack=0100", bits, ae, av); end
    endtask

    task automatic test_dreq;
        logic [31:0] bits; int nbits, fs, ae, bad; logic [3:0] av; logic es; bit hok, ctg;
        wr_addr[31:24] = 8'h03; wr_data[63:48] = 16'h9800;
        dreq = 1'b0; sdi_idle = 1'b1; req = 4'b1000;
        run_txn(300, -1, 100, 22, bits, nbits, fs, ae, av, es, hok, ctg, bad);
        checks++; if (fs != 101) begin failures++;
            $display("FAIL dreq_start: got first shift edge %0d, want 101", fs); end
        checks++; if (bits !== 32'h02039800 || nbits != 32 || !ctg) begin failures++;
            $display("FAIL dreq_contig: got %h (%0d bits, contig=%0d), want 02039800 (32, 1)", bits, nbits, ctg); end
        checks++; if (ae != 138 || av !== 4'b1000) begin failures++;
            $display("FAIL dreq_ack: got edge %0d ack=%b, want 138 1000", ae, av); end
        dreq = 1'b1;
    endtask

    task automatic test_contention;
        logic [7:0]  addrs [4] = '{8'h00, 8'h0B, 8'h02, 8'h03};
        logic [15:0] datas [4] = '{16'h0800, 16'h2020, 16'h7A15, 16'h9800};
        int order [5] = '{0, 1, 2, 3, 0};
        logic [31:0] bits; int nbits, fs, ae, bad, r; logic [3:0] av, want; logic es; bit hok, ctg;
        for (int i = 0; i < 4; i++) begin
            wr_addr[8*i +: 8] = addrs[i];
            wr_data[16*i +: 16] = datas[i];
        end
        dreq = 1'b1; sdi_idle = 1'b1; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_txn(100, -1, -1, 0, bits, nbits, fs, ae, av, es, hok, ctg, bad);
            r = order[k];
            want = 4'b0001 << r;
            checks++; if (av !== want || ae != ACK_EDGE) begin failures++;
                $display("FAIL rr_order[%0d]: got ack=%b at edge %0d, want %b at %0d", k, av, ae, want, ACK_EDGE); end
            checks++; if (bits !== {8'h02, addrs[r], datas[r]}) begin failures++;
                $display("FAIL rr_data[%0d]: got %h, want %h", k, bits, {8'h02, addrs[r], datas[r]}); end
            if (k == 0) req[0] = 1'b1;
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [31:0] bits; int nbits, fs, ae, bad, n; logic [3:0] av; logic es; bit hok, ctg, hit, saw;
        wr_addr[15:8] = 8'h00; wr_data[31:16] = 16'h0804;
        dreq = 1'b1; sdi_idle = 1'b1; req = 4'b0010;
        n = 0; hit = 1'b0;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            if (xcs === 1'b0) n++;
            if (n == 16) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin failures++;
            $display("FAIL rst_reach_bit16: got %0d bits within 60 edges, want 16", n); end
        rst = 1'b0;
        #1;
        checks++; if ({xcs, sck_en, sdi_hold, busy} !== 4'b1000) begin failures++;
            $display("FAIL rst_immediate: got xcs=%b sck_en=%b hold=%b busy=%b, want 1 0 0 0", xcs, sck_en, sdi_hold, busy); end
        req = 4'b0000; saw = 1'b0;
        repeat (5) begin @(posedge clk); if (ack !== 4'b0000) saw = 1'b1; end
        checks++; if (saw) begin failures++;
            $display("FAIL rst_no_ack: got ack during reset, want none"); end
        rst = 1'b1; req = 4'b0010;
        run_txn(100, -1, -1, 0, bits, nbits, fs, ae, av, es, hok, ctg, bad);
        checks++; if (bits !== 32'h02000804 || nbits != 32 || fs != 3 || ae != ACK_EDGE) begin failures++;
            $display("FAIL rst_restart: got %h (%0d bits) shift %0d ack %0d, want 02000804 (32) 3 %0d", bits, nbits, fs, ae, ACK_EDGE); end
    endtask

    task automatic test_timeout;
        logic [31:0] bits; int nbits, fs, ae, bad; logic [3:0] av; logic es; bit hok, ctg;
        dreq = 1'b0; sdi_idle = 1'b1; req = 4'b0001;
`ifdef MP3_SCI_TIMEOUT_EN
        run_txn(200, -1, -1, 0, bits, nbits, fs, ae, av, es, hok, ctg, bad);
        checks++; if (ae != 64 || av !== 4'b0001 || es !== 1'b1) begin failures++;
            $display("FAIL timeout_abort: got edge %0d ack=%b err=%b, want 64 0001 1", ae, av, es); end
        checks++; if (nbits != 0 || sdi_hold !== 1'b0) begin failures++;
            $display("FAIL timeout_no_shift: got %0d bits hold=%b, want 0 0", nbits, sdi_hold); end
`else
        run_txn(10000, -1, -1, 0, bits, nbits, fs, ae, av, es, hok, ctg, bad);
        checks++; if (ae != -1 || nbits != 0) begin failures++;
            $display("FAIL wait_forever: got ack edge %0d bits %0d, want none 0", ae, nbits); end
        checks++; if (busy !== 1'b1 || xcs !== 1'b1 || sdi_hold !== 1'b1 || err !== 1'b0) begin failures++;
            $display("FAIL wait_state: got busy=%b xcs=%b hold=%b err=%b, want 1 1 1 0", busy, xcs, sdi_hold, err); end
        rst = 1'b0; req = 4'b0000;
        @(posedge clk);
        rst = 1'b1;
`endif
        dreq = 1'b1;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_streamer_sync;
        test_dreq;
        test_contention;
        test_reset_mid_shift;
        test_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
